// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the datapath controller slice: opcode values,
// FSM state encoding, alu_load_src encodings, the PC register index and the
// control bundle that the instruction decoder hands to the controller FSM.
// No ports (package).
// ----------------------------------------------------------------------------
package datapath_pkg;

  // Opcodes live in instruction bits [15:12]; 1..9 are plain ALU operations.
  localparam logic [3:0] OP_HALT     = 4'h0;
  localparam logic [3:0] OP_ADD      = 4'h1;
  localparam logic [3:0] OP_LDI      = 4'hA;
  localparam logic [3:0] OP_BZ       = 4'hB;
  localparam logic [3:0] OP_ST       = 4'hC;
  localparam logic [3:0] OP_LD       = 4'hD;
  localparam logic [3:0] OP_PLOT     = 4'hE;
  localparam logic [3:0] OP_HALT_ALT = 4'hF;

  // Source that the datapath loads into register alu_out_select.
  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_ALU  = 2'b01;
  localparam logic [1:0] LOAD_MEM  = 2'b10;
  localparam logic [1:0] LOAD_STK  = 2'b11;

  // Register 0 is the program counter.
  localparam logic [3:0] PC_REG = 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEMWAIT,
    S_PLOT,
    S_HALT
  } state_t;

  // Everything the controller drives into the datapath for one cycle.
  typedef struct packed {
    logic        pc_inc;
    logic [3:0]  alu_op;
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  out_sel;
    logic        a_src;
    logic        b_src;
    logic [15:0] a_alt;
    logic [15:0] b_alt;
    logic [1:0]  load_src;
    logic        st_mem;
    logic        st_stk;
    logic [3:0]  color_sel;
    logic [3:0]  coord_sel;
    logic        plot;
  } ctrl_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_controller_instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Purely combinational decode of one instruction word into the control
// bundle for its execute cycle, the bundle for the optional follow-up cycle
// (MEMWAIT for LD, PLOT for PLOT) and the state the FSM moves to after EXEC.
// Ports:
//   instr      in  16  instruction word (opcode/d/a/b, imm8 = [7:0])
//   zero_set   in  1   datapath zero flag is nonzero (BZ condition)
//   exec_ctrl  out     controls for the EXEC cycle
//   wait_ctrl  out     controls for the MEMWAIT/PLOT cycle
//   exec_next  out     state following EXEC
// ----------------------------------------------------------------------------
import datapath_pkg::*;

module instr_decoder (
  input  logic [15:0] instr,
  input  logic        zero_set,
  output ctrl_t       exec_ctrl,
  output ctrl_t       wait_ctrl,
  output state_t      exec_next
);

  logic [3:0] op;
  logic [3:0] d;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] imm8;

  assign op   = instr[15:12];
  assign d    = instr[11:8];
  assign a    = instr[7:4];
  assign b    = instr[3:0];
  assign imm8 = instr[7:0];

  // A register write aimed at the PC replaces the normal increment.
  always_comb begin
    exec_ctrl = '0;
    wait_ctrl = '0;
    exec_next = S_FETCH;
    case (op) inside
      OP_HALT, OP_HALT_ALT: exec_next = S_HALT;
      [4'h1:4'h9]: begin
        exec_ctrl.alu_op   = op;
        exec_ctrl.a_sel    = a;
        exec_ctrl.b_sel    = b;
        exec_ctrl.out_sel  = d;
        exec_ctrl.load_src = LOAD_ALU;
        exec_ctrl.pc_inc   = (d != PC_REG);
      end
      OP_LDI: begin
        exec_ctrl.alu_op   = OP_ADD;
        exec_ctrl.a_src    = 1'b1;
        exec_ctrl.a_alt    = 16'h0000;
        exec_ctrl.b_src    = 1'b1;
        exec_ctrl.b_alt    = {8'h00, imm8};
        exec_ctrl.out_sel  = d;
        exec_ctrl.load_src = LOAD_ALU;
        exec_ctrl.pc_inc   = (d != PC_REG);
      end
      OP_BZ: begin
        // Taken branch: PC <= PC + sext(imm8) + 1, which also covers the step.
        if (zero_set) begin
          exec_ctrl.alu_op   = OP_ADD;
          exec_ctrl.a_sel    = PC_REG;
          exec_ctrl.b_src    = 1'b1;
          exec_ctrl.b_alt    = sext8(imm8) + 16'd1;
          exec_ctrl.out_sel  = PC_REG;
          exec_ctrl.load_src = LOAD_ALU;
        end else begin
          exec_ctrl.pc_inc = 1'b1;
        end
      end
      OP_ST: begin
        exec_ctrl.a_sel  = a;
        exec_ctrl.b_sel  = d;
        exec_ctrl.st_mem = 1'b1;
        exec_ctrl.pc_inc = 1'b1;
      end
      OP_LD: begin
        // Address stays selected while memory data settles in MEMWAIT.
        exec_ctrl.a_sel    = a;
        wait_ctrl.a_sel    = a;
        wait_ctrl.out_sel  = d;
        wait_ctrl.load_src = LOAD_MEM;
        wait_ctrl.pc_inc   = (d != PC_REG);
        exec_next          = S_MEMWAIT;
      end
      OP_PLOT: begin
        exec_ctrl.color_sel = d;
        exec_ctrl.coord_sel = a;
        wait_ctrl.color_sel = d;
        wait_ctrl.coord_sel = a;
        wait_ctrl.plot      = 1'b1;
        wait_ctrl.pc_inc    = 1'b1;
        exec_next           = S_PLOT;
      end
      default: exec_next = S_HALT;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// ----------------------------------------------------------------------------
// datapath_controller
// Multi-cycle control FSM for the 16-register datapath. Fetches the
// instruction at the PC, drives the decoded controls for one execute cycle
// (plus MEMWAIT/PLOT for LD/PLOT) and advances the PC (register 0).
// Optional macro DATAPATH_CONTROLLER_STEP_EN adds a 'step' input: FETCH then
// waits for step per instruction and run only matters for leaving IDLE/HALT.
// Parameter HALT_ON_ERROR (default 1): nonzero errorbit in EXEC forces HALT.
// Ports:
//   clock, resetn                  clock (rising) / async active-low reset
//   run                            level, starts and keeps fetching
//   step                           (macro only) single-step enable
//   current_instruction [15:0]     instruction at PC
//   zeroflag/signflag/errorbit     datapath flags, nonzero means set
//   program_counter_increment      PC += 1 at this edge
//   alu_op, alu_*_select           ALU operation / register indices
//   alu_a/b_source, alu_a/b_altern immediate operand selection and values
//   alu_load_src                   00 none, 01 ALU, 10 memory, 11 stack
//   alu_store_to_mem/stk           store strobes
//   vga_color/coord_select, vga_plot   plot register indices and strobe
//   halted                         FSM is in HALT
// ----------------------------------------------------------------------------
import datapath_pkg::*;

module datapath_controller #(
  parameter int HALT_ON_ERROR = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        run,
`ifdef DATAPATH_CONTROLLER_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] current_instruction,
  input  logic [15:0] zeroflag,
  input  logic [15:0] signflag,
  input  logic [15:0] errorbit,
  output logic        program_counter_increment,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_a_select,
  output logic [3:0]  alu_b_select,
  output logic [3:0]  alu_out_select,
  output logic        alu_a_source,
  output logic        alu_b_source,
  output logic [15:0] alu_a_altern,
  output logic [15:0] alu_b_altern,
  output logic [1:0]  alu_load_src,
  output logic        alu_store_to_mem,
  output logic        alu_store_to_stk,
  output logic [3:0]  vga_color_select,
  output logic [3:0]  vga_coord_select,
  output logic        vga_plot,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        halted_q, halted_d;
  logic        run_prev_q;

  logic [15:0] dec_instr;
  ctrl_t       exec_ctrl;
  ctrl_t       wait_ctrl;
  state_t      exec_next;
  logic        run_rise;
  logic        err_halt;
  logic        fetch_go;
  logic        fetch_abort;
  logic        unused_flags;

  // The sign flag is not consumed by any instruction yet.
  assign unused_flags = ^signflag;

  assign run_rise = run & ~run_prev_q;
  assign err_halt = (HALT_ON_ERROR != 0) && (state_q == S_EXEC) && (|errorbit);

`ifdef DATAPATH_CONTROLLER_STEP_EN
  assign fetch_go    = step;
  assign fetch_abort = 1'b0;
`else
  assign fetch_go    = 1'b1;
  assign fetch_abort = ~run;
`endif

  // In FETCH the word being latched is decoded directly so the EXEC controls
  // come out of a register on the very cycle EXEC starts.
  assign dec_instr = (state_q == S_FETCH) ? current_instruction : ir_q;

  instr_decoder u_decoder (
    .instr     (dec_instr),
    .zero_set  (|zeroflag),
    .exec_ctrl (exec_ctrl),
    .wait_ctrl (wait_ctrl),
    .exec_next (exec_next)
  );

  // Next state and next registered control bundle; strobes default low so
  // each one lasts exactly the single cycle it was loaded for.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ctrl_d  = '0;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_abort) begin
          state_d = S_IDLE;
        end else if (fetch_go) begin
          ir_d    = current_instruction;
          ctrl_d  = exec_ctrl;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (err_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = exec_next;
          if (exec_next inside {S_MEMWAIT, S_PLOT}) ctrl_d = wait_ctrl;
        end
      end
      S_MEMWAIT, S_PLOT: state_d = S_FETCH;
      S_HALT: if (run_rise) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    halted_d = (state_d == S_HALT);
  end

  // All state and outputs clear immediately on reset, aborting any strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      ctrl_q     <= '0;
      halted_q   <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ctrl_q     <= ctrl_d;
      halted_q   <= halted_d;
      run_prev_q <= run;
    end
  end

  // An error seen during EXEC must cancel the PC step issued for that same
  // cycle, so this one strobe is gated after its register.
  assign program_counter_increment = ctrl_q.pc_inc & ~err_halt;
  assign alu_op           = ctrl_q.alu_op;
  assign alu_a_select     = ctrl_q.a_sel;
  assign alu_b_select     = ctrl_q.b_sel;
  assign alu_out_select   = ctrl_q.out_sel;
  assign alu_a_source     = ctrl_q.a_src;
  assign alu_b_source     = ctrl_q.b_src;
  assign alu_a_altern     = ctrl_q.a_alt;
  assign alu_b_altern     = ctrl_q.b_alt;
  assign alu_load_src     = ctrl_q.load_src;
  assign alu_store_to_mem = ctrl_q.st_mem;
  assign alu_store_to_stk = ctrl_q.st_stk;
  assign vga_color_select = ctrl_q.color_sel;
  assign vga_coord_select = ctrl_q.coord_sel;
  assign vga_plot         = ctrl_q.plot;
  assign halted           = halted_q;

endmodule

// File: tb/tb_datapath_controller.sv
// ----------------------------------------------------------------------------
// tb_datapath_controller
// Directed-vector bench for datapath_controller (default build, macro
// DATAPATH_CONTROLLER_STEP_EN undefined). Inputs change and outputs are
// sampled 2 time units after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_datapath_controller;

  logic        clock;
  logic        resetn;
  logic        run;
  logic        step;
  logic [15:0] current_instruction;
  logic [15:0] zeroflag;
  logic [15:0] signflag;
  logic [15:0] errorbit;
  logic        program_counter_increment;
  logic [3:0]  alu_op;
  logic [3:0]  alu_a_select;
  logic [3:0]  alu_b_select;
  logic [3:0]  alu_out_select;
  logic        alu_a_source;
  logic        alu_b_source;
  logic [15:0] alu_a_altern;
  logic [15:0] alu_b_altern;
  logic [1:0]  alu_load_src;
  logic        alu_store_to_mem;
  logic        alu_store_to_stk;
  logic [3:0]  vga_color_select;
  logic [3:0]  vga_coord_select;
  logic        vga_plot;
  logic        halted;

  int compare_count  = 0;
  int mismatch_count = 0;

  datapath_controller #(.HALT_ON_ERROR(1)) dut (
    .clock                     (clock),
    .resetn                    (resetn),
    .run                       (run),
`ifdef DATAPATH_CONTROLLER_STEP_EN
    .step                      (step),
`endif
    .current_instruction       (current_instruction),
    .zeroflag                  (zeroflag),
    .signflag                  (signflag),
    .errorbit                  (errorbit),
    .program_counter_increment (program_counter_increment),
    .alu_op                    (alu_op),
    .alu_a_select              (alu_a_select),
    .alu_b_select              (alu_b_select),
    .alu_out_select            (alu_out_select),
    .alu_a_source              (alu_a_source),
    .alu_b_source              (alu_b_source),
    .alu_a_altern              (alu_a_altern),
    .alu_b_altern              (alu_b_altern),
    .alu_load_src              (alu_load_src),
    .alu_store_to_mem          (alu_store_to_mem),
    .alu_store_to_stk          (alu_store_to_stk),
    .vga_color_select          (vga_color_select),
    .vga_coord_select          (vga_coord_select),
    .vga_plot                  (vga_plot),
    .halted                    (halted)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] instr,
                               input logic [15:0] zf, input logic [15:0] err);
    run                 = r;
    current_instruction = instr;
    zeroflag            = zf;
    errorbit            = err;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #2;
  endtask

  initial begin
    resetn   = 1'b0;
    step     = 1'b1;
    signflag = 16'h0000;
    applyStimulus(1'b0, 16'hA702, 16'h0000, 16'h0000);
    #1;
    checkOutput("reset_pc_inc", 32'(program_counter_increment), 32'h0);
    checkOutput("reset_load", 32'(alu_load_src), 32'h0);
    checkOutput("reset_out_sel", 32'(alu_out_select), 32'h0);
    checkOutput("reset_b_alt", 32'(alu_b_altern), 32'h0);
    checkOutput("reset_halted", 32'(halted), 32'h0);

    // LDI r7, 0x02
    #2;
    resetn = 1'b1;
    applyStimulus(1'b1, 16'hA702, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("ldi_fetch_pc_inc", 32'(program_counter_increment), 32'h0);
    nextCycle();
    checkOutput("ldi_load", 32'(alu_load_src), 32'h1);
    checkOutput("ldi_out_sel", 32'(alu_out_select), 32'h7);
    checkOutput("ldi_b_src", 32'(alu_b_source), 32'h1);
    checkOutput("ldi_b_alt", 32'(alu_b_altern), 32'h0002);
    checkOutput("ldi_a_src", 32'(alu_a_source), 32'h1);
    checkOutput("ldi_alu_op", 32'(alu_op), 32'h1);
    checkOutput("ldi_pc_inc", 32'(program_counter_increment), 32'h1);

    // ALU op 1: r3 <= r1 op r2, two cycles
    applyStimulus(1'b1, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("alu_fetch_pc_inc", 32'(program_counter_increment), 32'h0);
    checkOutput("alu_fetch_load", 32'(alu_load_src), 32'h0);
    nextCycle();
    checkOutput("alu_op", 32'(alu_op), 32'h1);
    checkOutput("alu_a_sel", 32'(alu_a_select), 32'h1);
    checkOutput("alu_b_sel", 32'(alu_b_select), 32'h2);
    checkOutput("alu_out_sel", 32'(alu_out_select), 32'h3);
    checkOutput("alu_sources", 32'({alu_a_source, alu_b_source}), 32'h0);
    checkOutput("alu_pc_inc", 32'(program_counter_increment), 32'h1);

    // BZ taken: PC <= PC + FFFE + 1
    applyStimulus(1'b1, 16'hB0FE, 16'h0001, 16'h0000);
    nextCycle();
    checkOutput("alu_done_pc_inc", 32'(program_counter_increment), 32'h0);
    nextCycle();
    checkOutput("bz_t_out_sel", 32'(alu_out_select), 32'h0);
    checkOutput("bz_t_a_sel", 32'(alu_a_select), 32'h0);
    checkOutput("bz_t_b_alt", 32'(alu_b_altern), 32'hFFFF);
    checkOutput("bz_t_load", 32'(alu_load_src), 32'h1);
    checkOutput("bz_t_pc_inc", 32'(program_counter_increment), 32'h0);

    // BZ not taken: PC step only
    applyStimulus(1'b1, 16'hB0FE, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("bz_n_pc_inc", 32'(program_counter_increment), 32'h1);
    checkOutput("bz_n_load", 32'(alu_load_src), 32'h0);

    // LD r5 <= mem[r4], three cycles
    applyStimulus(1'b1, 16'hD540, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("ld_exec_pc_inc", 32'(program_counter_increment), 32'h0);
    checkOutput("ld_exec_load", 32'(alu_load_src), 32'h0);
    checkOutput("ld_exec_a_sel", 32'(alu_a_select), 32'h4);
    nextCycle();
    checkOutput("ld_wait_load", 32'(alu_load_src), 32'h2);
    checkOutput("ld_wait_out_sel", 32'(alu_out_select), 32'h5);
    checkOutput("ld_wait_pc_inc", 32'(program_counter_increment), 32'h1);

    // ALU write to r0: write replaces PC step
    applyStimulus(1'b1, 16'h1012, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("ld_done_load", 32'(alu_load_src), 32'h0);
    nextCycle();
    checkOutput("wr_pc_load", 32'(alu_load_src), 32'h1);
    checkOutput("wr_pc_pc_inc", 32'(program_counter_increment), 32'h0);

    // ST mem[r1] <= r3
    applyStimulus(1'b1, 16'hC312, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("st_strobe", 32'(alu_store_to_mem), 32'h1);
    checkOutput("st_a_sel", 32'(alu_a_select), 32'h1);
    checkOutput("st_b_sel", 32'(alu_b_select), 32'h3);
    checkOutput("st_pc_inc", 32'(program_counter_increment), 32'h1);

    // PLOT color r3 at coord r4, three cycles
    applyStimulus(1'b1, 16'hE340, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("st_strobe_off", 32'(alu_store_to_mem), 32'h0);
    nextCycle();
    checkOutput("plot_exec_color", 32'(vga_color_select), 32'h3);
    checkOutput("plot_exec_coord", 32'(vga_coord_select), 32'h4);
    checkOutput("plot_exec_strobe", 32'(vga_plot), 32'h0);
    checkOutput("plot_exec_pc_inc", 32'(program_counter_increment), 32'h0);
    nextCycle();
    checkOutput("plot_strobe", 32'(vga_plot), 32'h1);
    checkOutput("plot_pc_inc", 32'(program_counter_increment), 32'h1);
    nextCycle();
    checkOutput("plot_strobe_off", 32'(vga_plot), 32'h0);

    // Error raised during ALU EXEC
    applyStimulus(1'b1, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    errorbit = 16'h0001;
    #1;
    checkOutput("err_pc_inc", 32'(program_counter_increment), 32'h0);
    nextCycle();
    errorbit = 16'h0000;
    checkOutput("err_halted", 32'(halted), 32'h1);
    checkOutput("err_halt_pc_inc", 32'(program_counter_increment), 32'h0);

    // HALT only resumes on a fresh rising edge of run
    nextCycle();
    checkOutput("halt_hold_run_high", 32'(halted), 32'h1);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("halt_hold_run_low", 32'(halted), 32'h1);
    applyStimulus(1'b1, 16'h0000, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("resume_fetch", 32'(halted), 32'h0);
    nextCycle();
    checkOutput("halt_instr_exec", 32'(halted), 32'h0);
    checkOutput("halt_instr_pc_inc", 32'(program_counter_increment), 32'h0);
    nextCycle();
    checkOutput("halt_instr_halted", 32'(halted), 32'h1);

    // Resume, then drop run so FETCH falls back to IDLE
    applyStimulus(1'b0, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    applyStimulus(1'b1, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    checkOutput("resume2_fetch", 32'(halted), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("idle_pc_inc", 32'(program_counter_increment), 32'h0);
    checkOutput("idle_alu_op", 32'(alu_op), 32'h0);
    applyStimulus(1'b1, 16'h1312, 16'h0000, 16'h0000);
    nextCycle();
    nextCycle();
    checkOutput("idle_restart_pc_inc", 32'(program_counter_increment), 32'h1);

    // Reset in the middle of EXEC drops every strobe at once
    resetn = 1'b0;
    #1;
    checkOutput("abort_pc_inc", 32'(program_counter_increment), 32'h0);
    checkOutput("abort_load", 32'(alu_load_src), 32'h0);
    checkOutput("abort_out_sel", 32'(alu_out_select), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
